dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder for the pipeline's memory stage. It accepts one load/store request at a time, holds it for a configurable latency, then performs the access and returns a single-cycle response.
- rsp_valid is the signal the hazard logic consumes as the memory "valid"; it ends the load stall.
- Holds a word-organised, byte-writable data array and performs RV32I load extension and store byte-lane steering.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of 2).
LATENCY, 2, cycles from request acceptance to rsp_valid (>=1).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present (held by requester until accepted)
req_ready  out  1  responder can accept a request this cycle
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data; right-justified for SB/SH
req_funct3  in  3  RV32I load/store funct3
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  formatted load data; 0 for stores and errors
rsp_err  out  1  qualified by rsp_valid: access not performed

Behaviour:
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE); it is combinational.
- Accept when req_valid & req_ready in cycle T.
  - Capture we, addr, wdata and funct3.
  - LATENCY==1: go to RESP. Otherwise go to WAIT with counter = LATENCY-2.
- WAIT: decrement the counter each cycle; at 0, go to RESP.
  - rsp_valid is therefore asserted exactly in cycle T+LATENCY.
- RESP: rsp_valid=1 for one cycle, then return to IDLE.
  - Next acceptance is possible at T+LATENCY+1 at the earliest.
  - Peak throughput: one request per LATENCY+1 cycles.
- Array access occurs at the RESP edge from the captured request.
  - Stores write on entry to RESP.
  - Loads read registered data presented in RESP.
  - Load-after-store to the same address sees the new data.
- req_valid while not ready is ignored. Requester input changes are ignored outside acceptance.
- Word index = addr[log2(DEPTH)+1:2].
  - Out of range (addr[31:log2(DEPTH)+2] != 0): no write, rdata=0, rsp_err=1.
- Loads:
  - 000 LB: sign-extend byte addr[1:0].
  - 001 LH: sign-extend half addr[1].
  - 010 LW.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Stores:
  - 000 SB: byte enable 1<<addr[1:0], data replicated to all lanes.
  - 001 SH: enables 0011 or 1100 by addr[1].
  - 010 SW: 1111.
- Illegal funct3: load {011,110,111} or store {011..111}. Response is rsp_err=1, rdata=0, no write.
- Misaligned halves/words (base): low address bits are ignored and the access is aligned down; rsp_err=0.
- Reset values: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready=1 while in reset.
- Reset mid-operation aborts the transaction. A pending store is not written and no response is issued.
- Array contents are not reset.
- Outputs rsp_rdata/rsp_err are held at 0 when rsp_valid=0.

Optional Feature:
DMEM_MISALIGN_TRAP_EN defined:
- Halfword with addr[0]=1, or word with addr[1:0]!=0, gives no access, rdata=0, rsp_err=1.
Undefined:
- Align-down behaviour as above; rsp_err is never set for alignment.

Decomposition:
- Package dmem_pkg:
  - enum of the 3 FSM states.
  - funct3 localparams F3_B/H/W/BU/HU.
  - Function for load extension (funct3, byte offset, word -> 32b).
  - Function for store byte enables/lane data.
- One sub-module, dmem_sram: DEPTH x 32 array, 4 byte write enables, synchronous read, registered output.

Test Plan:
- Setup: LATENCY=2, DEPTH=1024.
- SW 0x10 data 0xDEADBEEF accepted at T -> rsp_valid at T+2, rsp_err=0; then LW 0x10 -> rsp_rdata 0xDEADBEEF two cycles after its acceptance.
- SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80ADBEEF.
- SH 0x12 data 0x9234 -> LH 0x12 = 0xFFFF9234, LHU 0x12 = 0x00009234, LW 0x10 = 0x9234BEEF.
- LW 0x1000 (out of range) -> rsp_valid at T+2, rsp_err=1, rdata 0; SW 0x1000 then LW 0x0 shows word 0 unchanged.
- req_valid held high with two back-to-back requests -> second accepted at T+3; req_ready low T+1..T+2; exactly one rsp_valid per request.
- Misaligned and reset cases:
  - LW 0x11: base build returns word 0x10 with rsp_err=0; macro build returns rsp_err=1.
  - reset_n pulsed low during WAIT of SW 0x20 data 0x1 -> no rsp_valid; later LW 0x20 returns the prior value; req_ready=1 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   state_e     - responder FSM states
//   req_t       - captured request fields
//   store_t     - byte enables plus lane-steered store data
//   F3_*        - RV32I load/store funct3 encodings
//   f3_legal    - funct3 legality for loads/stores
//   load_ext    - RV32I load extension from a raw word
//   store_lanes - RV32I store byte-enable and lane steering
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } req_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } store_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                     (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // off[0] is ignored for halves: misaligned halves are aligned down
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_W:    res = word;
            F3_BU:   res = {24'h0, b};
            F3_HU:   res = {16'h0, h};
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    function automatic store_t store_lanes(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] wdata);
        store_t s;
        s.be   = 4'b0000;
        s.data = wdata;
        case (f3)
            F3_B: begin
                s.be   = 4'b0001 << off;
                s.data = {4{wdata[7:0]}};
            end
            F3_H: begin
                s.be   = off[1] ? 4'b1100 : 4'b0011;
                s.data = {2{wdata[15:0]}};
            end
            F3_W:    s.be = 4'b1111;
            default: s.be = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH x 32-bit word array with per-byte write enables,
// synchronous read and a registered read-data output. Contents are not reset.
//   clk_i   - clock
//   en_i    - access enable (write when we_i, otherwise read)
//   we_i    - write select
//   be_i    - byte write enables
//   idx_i   - word index
//   wdata_i - lane-steered write data
//   rdata_o - registered read data (updated only on enabled reads)
module dmem_sram #(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the memory
// stage. Accepts one request, waits LATENCY cycles, performs the access and
// pulses rsp_valid for one cycle (rsp_valid releases the load stall).
//   clk, reset_n           - clock, asynchronous active-low reset
//   req_valid / req_ready  - request handshake (ready only in idle)
//   req_we, req_addr, req_wdata, req_funct3 - request fields
//   rsp_valid              - one-cycle response pulse
//   rsp_rdata              - formatted load data (0 for stores/errors)
//   rsp_err                - access not performed (range, funct3, alignment)
// Build option: define DMEM_MISALIGN_TRAP_EN to flag misaligned halfword/word
// accesses as errors instead of aligning them down.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    req_t            cap_q, cap_d;
    logic            err_q, err_d;

    req_t        req_in, sel;
    logic        go_resp;
    logic        oor, misalign, acc_err;
    store_t      lanes;
    logic        mem_en;
    logic [31:0] mem_rdata;

    assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};

    // With LATENCY==1 the access happens on the accepting edge, so the live
    // request must feed the array before it has been captured.
    assign sel = (state_q == StIdle) ? req_in : cap_q;

    assign oor = |(sel.addr >> (AW + 2));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((sel.funct3[1:0] == 2'b01) && sel.addr[0]) ||
                      ((sel.funct3 == F3_W) && (sel.addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign acc_err = oor | ~f3_legal(sel.we, sel.funct3) | misalign;
    assign lanes   = store_lanes(sel.funct3, sel.addr[1:0], sel.wdata);

    // Gating with reset_n keeps an aborted transaction from touching the array.
    assign mem_en = go_resp & ~acc_err & reset_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        go_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cap_d = req_in;
                    if (LATENCY == 1) begin
                        state_d = StResp;
                        go_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(LATENCY - 2);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        err_d = go_resp ? acc_err : err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    dmem_sram #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk_i  (clk),
        .en_i   (mem_en),
        .we_i   (sel.we),
        .be_i   (lanes.be),
        .idx_i  (sel.addr[AW+1:2]),
        .wdata_i(lanes.data),
        .rdata_o(mem_rdata)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !cap_q.we)
                       ? load_ext(cap_q.funct3, cap_q.addr[1:0], mem_rdata) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder
// (DEPTH=1024, LATENCY=2). Expected responses are queued at acceptance and
// checked against each rsp_valid pulse, including its cycle of arrival.
module tb_dmem_responder;

    localparam int LAT = 2;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    dmem_responder #(
        .DEPTH  (1024),
        .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Call at posedge+#1. Holds req_valid until accepted (bounded), queues the
    // expected response when want is set, then scrambles the idle inputs.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [31:0] erd, input logic eerr,
                         input bit want, output int acc, output int waits);
        exp_t e;
        req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        req_valid = 1'b1;
        acc = -1;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            waits++;
        end
        if (acc < 0) begin
            n_checks++;
            $error("FAIL accept_timeout: observed no acceptance expected acceptance in 20 cycles");
        end else if (want) begin
            e.rdata = erd; e.err = eerr; e.cyc = acc + LAT;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom);
    endtask

    task automatic ld(input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] erd, input logic eerr);
        int a, w;
        issue(1'b0, addr, 32'h0, f3, erd, eerr, 1'b1, a, w);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                      input logic eerr);
        int a, w;
        issue(1'b1, addr, wdata, f3, 32'h0, eerr, 1'b1, a, w);
    endtask

    initial begin
        int a1, w1, a2, w2;
        exp_t e;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        fork
            forever begin
                @(negedge clk);
                if (rsp_valid === 1'b1) begin
                    n_checks++;
                    assert (sb.size() != 0) n_pass++;
                    else $error("FAIL unexpected_rsp: observed rsp_valid=1 at cycle %0d expected no response", cyc);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end else if (reset_n === 1'b1) begin
                    chk("idle_rdata_zero", rsp_rdata, 32'h0);
                    chk("idle_err_zero", {31'h0, rsp_err}, 32'h0);
                end
            end
        join_none

        // Word, byte and half stores/loads with extension
        st(32'h10, 32'hDEADBEEF, LW, 1'b0);
        ld(32'h10, LW, 32'hDEADBEEF, 1'b0);
        st(32'h13, 32'h00000080, LB, 1'b0);
        ld(32'h13, LB, 32'hFFFFFF80, 1'b0);
        ld(32'h13, LBU, 32'h00000080, 1'b0);
        ld(32'h10, LW, 32'h80ADBEEF, 1'b0);
        st(32'h12, 32'h00009234, LH, 1'b0);
        ld(32'h12, LH, 32'hFFFF9234, 1'b0);
        ld(32'h12, LHU, 32'h00009234, 1'b0);
        ld(32'h10, LW, 32'h9234BEEF, 1'b0);

        // Out-of-range accesses
        st(32'h0, 32'h12345678, LW, 1'b0);
        ld(32'h1000, LW, 32'h0, 1'b1);
        st(32'h1000, 32'hFFFFFFFF, LW, 1'b1);
        ld(32'h0, LW, 32'h12345678, 1'b0);

        // Illegal funct3: error response and no write
        ld(32'h10, 3'b011, 32'h0, 1'b1);
        st(32'h0, 32'h0, 3'b111, 1'b1);
        ld(32'h0, LW, 32'h12345678, 1'b0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
        ld(32'h11, LW, 32'h0, 1'b1);
        ld(32'h13, LH, 32'h0, 1'b1);
`else
        ld(32'h11, LW, 32'h9234BEEF, 1'b0);
        ld(32'h13, LH, 32'hFFFF9234, 1'b0);
`endif

        // Reset during WAIT aborts a store without a response
        st(32'h20, 32'h55555555, LW, 1'b0);
        issue(1'b1, 32'h20, 32'h00000001, LW, 32'h0, 1'b0, 1'b0, a1, w1);
        reset_n = 1'b0;
        #1;
        chk("ready_in_reset", {31'h0, req_ready}, 32'h1);
        chk("no_rsp_in_reset", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
        ld(32'h20, LW, 32'h55555555, 1'b0);

        // Back-to-back with req_valid held high
        issue(1'b0, 32'h10, 32'h0, LW, 32'h9234BEEF, 1'b0, 1'b1, a1, w1);
        issue(1'b0, 32'h0, 32'h0, LW, 32'h12345678, 1'b0, 1'b1, a2, w2);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
        chk("b2b_ready_low_cycles", 32'(w2), 32'd2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
